// File: rtl/despachador_nonces_pkg.sv
// Shared types and widths for the nonce dispatcher (despachador_nonces).
// The optional search timeout is controlled by DESPACHADOR_TIMEOUT_EN.
package despachador_pkg;

    localparam int ANCHO_NONCE  = 32;
    localparam int ANCHO_BOUNTY = 24;
    localparam int ANCHO_BLOQUE = 96;
    localparam int ANCHO_TARGET = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARRANQUE  = 2'd1,
        BUSQUEDA  = 2'd2,
        RESULTADO = 2'd3
    } estado_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ANCHO_NONCE-1:0] sumar_sat(input logic [ANCHO_NONCE-1:0] a);
        return (a == {ANCHO_NONCE{1'b1}}) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/despachador_nonces_if.sv
// Bundle of job, result and hash-unit signals around the dispatcher.
// master = dispatcher side, slave = job source / result sink / hash unit side.
interface despachador_nonces_if #(
    parameter int NUM_BLOQUES_PARALELOS = 4
);
    // Both job_* and res_* are valid/ready: a transfer happens on a rising edge
    // where valid and ready are both 1; valid holds with stable payload until then.
    logic                                               job_valid;
    logic                                               job_ready;
    logic [despachador_pkg::ANCHO_BLOQUE-1:0]           job_bloque_datos;
    logic [despachador_pkg::ANCHO_TARGET-1:0]           job_target;
    logic [despachador_pkg::ANCHO_NONCE-1:0]            job_nonce_base;

    logic [despachador_pkg::ANCHO_BLOQUE-1:0]           bloque_datos;
    logic [despachador_pkg::ANCHO_TARGET-1:0]           target;
    logic [despachador_pkg::ANCHO_NONCE*NUM_BLOQUES_PARALELOS-1:0] nonce_iniciales;
    logic                                               inicio;
    logic [despachador_pkg::ANCHO_BOUNTY-1:0]           bounty_out;
    logic                                               terminado_out;

    logic                                               res_valid;
    logic                                               res_ready;
    logic [despachador_pkg::ANCHO_BOUNTY-1:0]           res_bounty;
    logic                                               res_timeout;
    logic [despachador_pkg::ANCHO_NONCE-1:0]            res_ciclos;

    logic [1:0]                                         estado_dbg;

    modport master (
        input  job_valid, job_bloque_datos, job_target, job_nonce_base,
        input  bounty_out, terminado_out, res_ready,
        output job_ready, bloque_datos, target, nonce_iniciales, inicio,
        output res_valid, res_bounty, res_timeout, res_ciclos, estado_dbg
    );

    modport slave (
        output job_valid, job_bloque_datos, job_target, job_nonce_base,
        output bounty_out, terminado_out, res_ready,
        input  job_ready, bloque_datos, target, nonce_iniciales, inicio,
        input  res_valid, res_bounty, res_timeout, res_ciclos, estado_dbg
    );

endinterface

// File: rtl/despachador_nonces_contador_busqueda.sv
// Saturating search-cycle counter; the limit flag exists only when
// DESPACHADOR_TIMEOUT_EN is defined.
module contador_busqueda
    import despachador_pkg::*;
#(
    parameter int unsigned MAX_CICLOS = 1048576
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr_i,
    input  logic                   en_i,
    // Count including the current cycle, i.e. the value stored on this edge.
    output logic [ANCHO_NONCE-1:0] cuenta_o
`ifdef DESPACHADOR_TIMEOUT_EN
    ,
    output logic                   limite_alcanzado_o
`endif
);

    logic [ANCHO_NONCE-1:0] cuenta_q;

    assign cuenta_o = sumar_sat(cuenta_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cuenta_q <= '0;
        end else if (clr_i) begin
            cuenta_q <= '0;
        end else if (en_i) begin
            cuenta_q <= cuenta_o;
        end
    end

`ifdef DESPACHADOR_TIMEOUT_EN
    localparam logic [ANCHO_NONCE-1:0] LIMITE = ANCHO_NONCE'(MAX_CICLOS);

    assign limite_alcanzado_o = en_i && (cuenta_o >= LIMITE);
`endif

endmodule

// File: rtl/despachador_nonces.sv
// Job dispatcher in front of the parallel hash unit: splits the nonce space,
// runs one search, returns bounty and cycle count. Timeout: DESPACHADOR_TIMEOUT_EN.
module despachador_nonces
    import despachador_pkg::*;
#(
    parameter int          NUM_BLOQUES_PARALELOS = 4,
    parameter int unsigned MAX_CICLOS            = 1048576
) (
    input  logic                    clk,
    input  logic                    reset_n,
    despachador_nonces_if.master    bus
);

    localparam int ANCHO_NONCES = ANCHO_NONCE * NUM_BLOQUES_PARALELOS;

    if (MAX_CICLOS == 0) begin : g_max_ciclos_invalido
        $error("MAX_CICLOS must be at least 1");
    end

    estado_e                  estado_q, estado_d;
    logic [ANCHO_BLOQUE-1:0]  bloque_q;
    logic [ANCHO_TARGET-1:0]  target_q;
    logic [ANCHO_NONCES-1:0]  nonces_q, nonces_d;
    logic                     inicio_q;
    logic                     res_valid_q, res_valid_d;
    logic [ANCHO_BOUNTY-1:0]  res_bounty_q, res_bounty_d;
    logic [ANCHO_NONCE-1:0]   res_ciclos_q, res_ciclos_d;
    logic [ANCHO_NONCE-1:0]   cuenta;
    logic                     aceptar_job;
    logic                     fin_hash;
    logic                     fin_tiempo;

    assign aceptar_job = (estado_q == IDLE) && bus.job_valid;
    // terminado_out only counts in BUSQUEDA; during ARRANQUE it is stale.
    assign fin_hash    = (estado_q == BUSQUEDA) && bus.terminado_out;

`ifdef DESPACHADOR_TIMEOUT_EN
    logic limite_alcanzado;
    logic res_timeout_q, res_timeout_d;

    contador_busqueda #(
        .MAX_CICLOS         (MAX_CICLOS)
    ) u_contador (
        .clk                (clk),
        .reset_n            (reset_n),
        .clr_i              (estado_q != BUSQUEDA),
        .en_i               (estado_q == BUSQUEDA),
        .cuenta_o           (cuenta),
        .limite_alcanzado_o (limite_alcanzado)
    );

    // A hash found on the limit cycle takes precedence over the timeout.
    assign fin_tiempo = limite_alcanzado && !fin_hash;
`else
    contador_busqueda #(
        .MAX_CICLOS (MAX_CICLOS)
    ) u_contador (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (estado_q != BUSQUEDA),
        .en_i       (estado_q == BUSQUEDA),
        .cuenta_o   (cuenta)
    );

    assign fin_tiempo = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:      if (aceptar_job) estado_d = ARRANQUE;
            ARRANQUE:  estado_d = BUSQUEDA;
            BUSQUEDA:  if (fin_hash || fin_tiempo) estado_d = RESULTADO;
            RESULTADO: if (bus.res_ready) estado_d = IDLE;
            default:   estado_d = IDLE;
        endcase
    end

    always_comb begin
        nonces_d = '0;
        for (int i = 0; i < NUM_BLOQUES_PARALELOS; i++) begin
            nonces_d[ANCHO_NONCE*i +: ANCHO_NONCE] = bus.job_nonce_base + ANCHO_NONCE'(i);
        end
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_bounty_d = res_bounty_q;
        res_ciclos_d = res_ciclos_q;
`ifdef DESPACHADOR_TIMEOUT_EN
        res_timeout_d = res_timeout_q;
`endif
        if (fin_hash) begin
            res_valid_d  = 1'b1;
            res_bounty_d = bus.bounty_out;
            res_ciclos_d = cuenta;
`ifdef DESPACHADOR_TIMEOUT_EN
            res_timeout_d = 1'b0;
`endif
        end else if (fin_tiempo) begin
            res_valid_d  = 1'b1;
            res_bounty_d = '0;
            res_ciclos_d = cuenta;
`ifdef DESPACHADOR_TIMEOUT_EN
            res_timeout_d = 1'b1;
`endif
        end else if ((estado_q == RESULTADO) && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= IDLE;
            inicio_q     <= 1'b1;
            res_valid_q  <= 1'b0;
            res_bounty_q <= '0;
            res_ciclos_q <= '0;
        end else begin
            estado_q     <= estado_d;
            inicio_q     <= (estado_d != BUSQUEDA);
            res_valid_q  <= res_valid_d;
            res_bounty_q <= res_bounty_d;
            res_ciclos_q <= res_ciclos_d;
        end
    end

`ifdef DESPACHADOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_timeout_q <= 1'b0;
        end else begin
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.res_timeout = res_timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    // Hash-unit inputs keep the last job until a new one is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bloque_q <= '0;
            target_q <= '0;
            nonces_q <= '0;
        end else if (aceptar_job) begin
            bloque_q <= bus.job_bloque_datos;
            target_q <= bus.job_target;
            nonces_q <= nonces_d;
        end
    end

    assign bus.job_ready       = (estado_q == IDLE);
    assign bus.bloque_datos    = bloque_q;
    assign bus.target          = target_q;
    assign bus.nonce_iniciales = nonces_q;
    assign bus.inicio          = inicio_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_bounty      = res_bounty_q;
    assign bus.res_ciclos      = res_ciclos_q;
    assign bus.estado_dbg      = estado_q;

endmodule

// File: tb/tb_despachador_nonces.sv
// Directed bench for despachador_nonces with a job/result model and a per-cycle
// compare process; timeout cases follow DESPACHADOR_TIMEOUT_EN.
module tb_despachador_nonces;

    localparam int N   = 4;
    localparam int MAX = 16;
    localparam int W   = 57; // {bounty[23:0], timeout, ciclos[31:0]}

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    bit   model_on;

    logic [95:0]   m_bloque;
    logic [7:0]    m_target;
    logic [127:0]  m_nonces;
    logic [W-1:0]  exp_q[$];

    despachador_nonces_if #(.NUM_BLOQUES_PARALELOS(N)) bus();

    despachador_nonces #(
        .NUM_BLOQUES_PARALELOS (N),
        .MAX_CICLOS            (MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [127:0] actual, input logic [127:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nombre, actual, esperado);
        end
    endtask

    function automatic logic [127:0] model_nonces(input logic [31:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("hash_bloque", {32'h0, bus.bloque_datos}, {32'h0, m_bloque});
            chk("hash_target", {120'h0, bus.target}, {120'h0, m_target});
            chk("hash_nonces", bus.nonce_iniciales, m_nonces);
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("res_inesperado", {127'h0, bus.res_valid}, 128'h0);
                end else begin
                    chk("res_bounty", {104'h0, bus.res_bounty}, {104'h0, exp_q[0][56:33]});
                    chk("res_timeout", {127'h0, bus.res_timeout}, {127'h0, exp_q[0][32]});
                    chk("res_ciclos", {96'h0, bus.res_ciclos}, {96'h0, exp_q[0][31:0]});
                end
            end
        end
    end

    always @(posedge clk) begin
        if (model_on && reset_n && bus.res_valid && bus.res_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    task automatic enviar_job(input logic [95:0] bloque, input logic [7:0] tgt, input logic [31:0] base);
        bit ok;
        ok = 1'b0;
        bus.job_valid        = 1'b1;
        bus.job_bloque_datos = bloque;
        bus.job_target       = tgt;
        bus.job_nonce_base   = base;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("job_handshake_timeout", 128'h0, 128'h1);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        m_bloque = bloque;
        m_target = tgt;
        m_nonces = model_nonces(base);
        chk("arranque_inicio", {127'h0, bus.inicio}, 128'h1);
        chk("arranque_job_ready", {127'h0, bus.job_ready}, 128'h0);
    endtask

    // Called right after the job handshake; pulses terminado_out on BUSQUEDA cycle n.
    task automatic buscar(input int n, input logic [23:0] bounty, input bit pulso_arranque);
        bus.terminado_out = pulso_arranque;
        bus.bounty_out    = 24'h5A5A5A;
        @(posedge clk);
        #1;
        bus.terminado_out = 1'b0;
        chk("busqueda_inicio", {127'h0, bus.inicio}, 128'h0);
        repeat (n - 1) @(posedge clk);
        #1;
        bus.bounty_out    = bounty;
        bus.terminado_out = 1'b1;
        exp_q.push_back({bounty, 1'b0, 32'(n)});
        @(posedge clk);
        #1;
        bus.terminado_out = 1'b0;
        bus.bounty_out    = 24'h000000;
    endtask

    task automatic recoger(input int espera);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("res_valid_timeout", 128'h0, 128'h1);
        if (espera > 0) begin
            bus.job_valid        = 1'b1;
            bus.job_bloque_datos = 96'hFEED_FEED_FEED_FEED_FEED_FEED;
            bus.job_target       = 8'hEE;
            bus.job_nonce_base   = 32'h7777_0000;
            repeat (espera) begin
                @(negedge clk);
                chk("espera_job_ready", {127'h0, bus.job_ready}, 128'h0);
                chk("espera_res_valid", {127'h0, bus.res_valid}, 128'h1);
            end
        end
        @(negedge clk);
        #1;
        bus.res_ready = 1'b1;
        bus.job_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("idle_job_ready", {127'h0, bus.job_ready}, 128'h1);
        chk("idle_res_valid", {127'h0, bus.res_valid}, 128'h0);
        chk("idle_inicio", {127'h0, bus.inicio}, 128'h1);
    endtask

    task automatic chk_reset(input string etapa);
        chk({etapa, "_job_ready"}, {127'h0, bus.job_ready}, 128'h1);
        chk({etapa, "_inicio"}, {127'h0, bus.inicio}, 128'h1);
        chk({etapa, "_res_valid"}, {127'h0, bus.res_valid}, 128'h0);
        chk({etapa, "_res_timeout"}, {127'h0, bus.res_timeout}, 128'h0);
        chk({etapa, "_res_bounty"}, {104'h0, bus.res_bounty}, 128'h0);
        chk({etapa, "_res_ciclos"}, {96'h0, bus.res_ciclos}, 128'h0);
        chk({etapa, "_bloque"}, {32'h0, bus.bloque_datos}, 128'h0);
        chk({etapa, "_target"}, {120'h0, bus.target}, 128'h0);
        chk({etapa, "_nonces"}, bus.nonce_iniciales, 128'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_on = 1'b0;
        m_bloque = '0;
        m_target = '0;
        m_nonces = '0;
        reset_n = 1'b0;
        bus.job_valid        = 1'b0;
        bus.job_bloque_datos = '0;
        bus.job_target       = '0;
        bus.job_nonce_base   = '0;
        bus.bounty_out       = '0;
        bus.terminado_out    = 1'b0;
        bus.res_ready        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        model_on = 1'b1;
        reset_n = 1'b1;

        // Base 0000_1000, hash found on BUSQUEDA cycle 5.
        enviar_job(96'h0102_0304_0506_0708_090A_0B0C, 8'h1F, 32'h0000_1000);
        chk("nonces_1000", bus.nonce_iniciales, 128'h00001003_00001002_00001001_00001000);
        buscar(5, 24'hABCDEF, 1'b0);
        chk("cola_abcdef", {71'h0, exp_q[0]}, {71'h0, 24'hABCDEF, 1'b0, 32'd5});
        recoger(0);

        // Nonce wrap-around, minimum latency search.
        enviar_job(96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 8'h02, 32'hFFFF_FFFE);
        chk("nonces_wrap", bus.nonce_iniciales, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE);
        buscar(1, 24'h000001, 1'b0);
        recoger(0);

        // Stale terminado_out during ARRANQUE, then result held for 10 cycles.
        enviar_job(96'h1111_2222_3333_4444_5555_6666, 8'h33, 32'h8000_0000);
        buscar(3, 24'h123ABC, 1'b1);
        recoger(10);

        // Hash found exactly on the limit cycle: the hash wins.
        enviar_job(96'h0, 8'hFF, 32'h0000_0010);
        buscar(MAX, 24'h654321, 1'b0);
        recoger(0);

`ifdef DESPACHADOR_TIMEOUT_EN
        // No hash at all: timeout after MAX cycles with zero bounty.
        enviar_job(96'h9999_8888_7777_6666_5555_4444, 8'h44, 32'h0000_0100);
        bus.bounty_out = 24'hDEAD00;
        exp_q.push_back({24'h000000, 1'b1, 32'd16});
        recoger(0);
        bus.bounty_out = 24'h000000;
`else
        // No timeout: the search runs well past MAX until terminado_out.
        enviar_job(96'h9999_8888_7777_6666_5555_4444, 8'h44, 32'h0000_0100);
        buscar(40, 24'h0F0F0F, 1'b0);
        recoger(0);
`endif

        // Asynchronous reset in the middle of a search.
        enviar_job(96'hCAFE_CAFE_CAFE_CAFE_CAFE_CAFE, 8'h55, 32'h0000_2000);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        m_bloque = '0;
        m_target = '0;
        m_nonces = '0;
        exp_q.delete();
        #2;
        chk_reset("reset_medio");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Recovery after reset.
        enviar_job(96'h0000_0000_0000_0000_0000_0042, 8'h07, 32'h0000_3000);
        buscar(2, 24'h0000AA, 1'b0);
        recoger(0);

        repeat (2) @(posedge clk);
        chk("cola_vacia", 128'(exp_q.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
